alu_share_arbiter: RTL

//  Shares one combinational ALU between N requesters: integer pipe, branch-target calc, AGU, ...

---
 rtl/alu_share_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter
// Brief    : Round-robin sharing of one combinational ALU among N_REQ
//            requesters, with a registered response slot per requester.
// Revision : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int N_REQ        = 2,
    parameter int FUNC_W       = 4,
    parameter int FUNC_DISABLE = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*32-1:0]     req_op1,
    input  logic [N_REQ*32-1:0]     req_op2,
    input  logic [N_REQ*FUNC_W-1:0] req_func,
    output logic [31:0]             alu_op1,
    output logic [31:0]             alu_op2,
    output logic [FUNC_W-1:0]       alu_function,
    input  logic [31:0]             alu_res,
    output logic [N_REQ-1:0]        rsp_valid,
    input  logic [N_REQ-1:0]        rsp_ready,
    output logic [N_REQ*32-1:0]     rsp_data,
    output logic                    busy
);

    localparam int                PTR_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [FUNC_W-1:0] c_FUNC_OFF = FUNC_W'(FUNC_DISABLE);

    logic [PTR_W-1:0]    r_ptr;
    logic [N_REQ-1:0]    r_rsp_valid;
    logic [N_REQ*32-1:0] r_rsp_data;

    logic [N_REQ-1:0]    w_free;
    logic [N_REQ-1:0]    w_elig;
    logic [N_REQ-1:0]    w_cand;
    logic                w_xfer;
    logic [PTR_W-1:0]    w_gnt_idx;
    logic                w_gnt_vld;
    logic [N_REQ-1:0]    w_req_ready;

    assign w_free = ~r_rsp_valid | rsp_ready;
    assign w_elig = req_valid & w_free;
    // When nobody is eligible, ready is still offered to the next free slot so
    // that ready never waits on valid; no transfer can occur in that case.
    assign w_xfer = |w_elig;
    assign w_cand = w_xfer ? w_elig : w_free;

    always_comb begin
        int idx;
        w_gnt_idx   = '0;
        w_gnt_vld   = 1'b0;
        w_req_ready = '0;
        // Descending scan so the candidate closest to r_ptr wins last.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(r_ptr) + k) % N_REQ;
            if (w_cand[idx]) begin
                w_gnt_idx = PTR_W'(idx);
                w_gnt_vld = 1'b1;
            end
        end
        if (w_gnt_vld) begin
            w_req_ready[w_gnt_idx] = 1'b1;
        end
    end

    assign req_ready    = w_req_ready;
    assign alu_op1      = w_xfer ? req_op1[32*w_gnt_idx +: 32] : 32'd0;
    assign alu_op2      = w_xfer ? req_op2[32*w_gnt_idx +: 32] : 32'd0;
    assign alu_function = w_xfer ? req_func[FUNC_W*w_gnt_idx +: FUNC_W] : c_FUNC_OFF;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= (int'(w_gnt_idx) == N_REQ - 1) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_xfer && (w_gnt_idx == PTR_W'(i))) begin
                    r_rsp_data[32*i +: 32] <= alu_res;
                    r_rsp_valid[i]         <= 1'b1;
                end else if (rsp_ready[i]) begin
                    r_rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign busy      = (|r_rsp_valid) | (|req_valid);

endmodule
`default_nettype wire
